// File: rtl/circular_dma_pkg.sv
// circular_dma_pkg: shared types, constants and helpers for the circular DMA burst scheduler
package circular_dma_pkg;
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_RESP, S_ERROR} sched_state_t;
   localparam int unsigned C_4K_BYTES = 4096;
   function automatic int unsigned beat_bytes(input int unsigned width);
      return width / 8;
   endfunction
   function automatic logic [31:0] min3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      logic [31:0] m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction
   function automatic logic [31:0] min4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
      return min3(a, b, (c < d) ? c : d);
   endfunction
endpackage

// File: rtl/circular_dma_timeout_timer.sv
// circular_dma_timeout_timer: partial-burst timeout counter.
// Ports: clk, rst (sync, active high), run (count request), clr (restart on issue),
//        timeout (cycles, 0 disables), expired (count reached timeout-1 while running).
module circular_dma_timeout_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        clr,
   input  logic [31:0] timeout,
   output logic        expired
);
   logic [31:0] count;
   assign expired = run && timeout != '0 && count == timeout - 32'd1;
   always_ff @(posedge clk)
      count <= (rst || !run || clr || expired) ? '0 : count + 32'd1;
endmodule

// File: rtl/circular_dma_burst_sched.sv
// circular_dma_burst_sched: schedules AXI4 write bursts from the stream FIFO into a circular buffer.
// Ports: clk, rst/srst (sync resets), enable, mem_base/mem_size/timeout (config), fifo_words,
//        flush_fifo, cmd_valid/cmd_ready/cmd_addr/cmd_len (burst command), done_valid/done_err
//        (completion), bytes_written, status_flags {error, waiting_timeout, busy},
//        irq {write_error, wrapped, timeout_flush}, clear_irq (per-bit clear).
module circular_dma_burst_sched
   import circular_dma_pkg::*;
#(
   parameter int C_ADDR_WIDTH = 32,
   parameter int C_AXIS_WIDTH = 64,
   parameter int C_MAX_BURST  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    srst,
   input  logic [C_ADDR_WIDTH-1:0] mem_base,
   input  logic [31:0]             mem_size,
   input  logic [31:0]             timeout,
   input  logic [15:0]             fifo_words,
   input  logic                    flush_fifo,
   output logic                    cmd_valid,
   input  logic                    cmd_ready,
   output logic [C_ADDR_WIDTH-1:0] cmd_addr,
   output logic [7:0]              cmd_len,
   input  logic                    done_valid,
   input  logic                    done_err,
   output logic [31:0]             bytes_written,
   output logic [2:0]              status_flags,
   output logic [2:0]              irq,
   input  logic [2:0]              clear_irq
);
   localparam int unsigned B = beat_bytes(C_AXIS_WIDTH);
   localparam logic [31:0] MAX_BEATS = 32'(C_MAX_BURST);
   localparam logic [31:0] BURST_BYTES = 32'(C_MAX_BURST * B);
   sched_state_t state;
   logic [31:0] offset, fifo32, page_rem, buf_rem, beats, next_off;
   logic [C_ADDR_WIDTH-1:0] addr;
   logic run, expired, trigger, wrap, done_ok;
   logic [2:0] irq_set;
   always_comb begin
      fifo32   = {16'd0, fifo_words};
      run      = state == S_WAIT && enable && fifo32 != '0 && fifo32 < MAX_BEATS && timeout != '0;
      addr     = mem_base + C_ADDR_WIDTH'(offset);
      page_rem = (32'(C_4K_BYTES) - {20'd0, addr[11:0]}) / 32'(B);
      buf_rem  = (mem_size - offset) / 32'(B);
      beats    = min4(fifo32, MAX_BEATS, buf_rem, page_rem);
      trigger  = fifo32 >= MAX_BEATS || (fifo32 != '0 && (flush_fifo || expired));
      next_off = offset + ({24'd0, cmd_len} + 32'd1) * 32'(B);
      // >= rather than == keeps a shrunk mem_size from running the offset off the end
      wrap     = next_off >= mem_size;
      done_ok  = state == S_RESP && done_valid && !done_err;
      irq_set  = {state == S_RESP && done_valid && done_err, done_ok && wrap, state == S_WAIT && expired};
   end
   assign status_flags = {state == S_ERROR, run, state == S_ISSUE || state == S_RESP};
   circular_dma_timeout_timer u_timer (
      .clk    (clk),
      .rst    (rst || srst),
      .run    (run),
      .clr    (state == S_WAIT && enable && trigger),
      .timeout(timeout),
      .expired(expired)
   );
   always_ff @(posedge clk) begin
      if (rst || srst) begin
         state         <= S_IDLE;
         cmd_valid     <= 1'b0;
         cmd_addr      <= '0;
         cmd_len       <= '0;
         bytes_written <= '0;
         offset        <= '0;
         irq           <= '0;
      end else begin
         irq <= (irq & ~clear_irq) | irq_set;
         case (state)
            S_IDLE: if (enable) begin
               state         <= (mem_size >= BURST_BYTES) ? S_WAIT : S_ERROR;
               offset        <= '0;
               bytes_written <= '0;
            end
            S_WAIT: if (!enable) state <= S_IDLE;
            else if (trigger) begin
               cmd_addr  <= addr;
               cmd_len   <= 8'(beats - 32'd1);
               cmd_valid <= 1'b1;
               state     <= S_ISSUE;
            end
            S_ISSUE: if (cmd_ready) begin
               cmd_valid <= 1'b0;
               state     <= S_RESP;
            end
            S_RESP: if (done_valid) begin
               if (done_err) state <= S_ERROR;
               else begin
                  offset        <= wrap ? '0 : next_off;
                  bytes_written <= wrap ? '0 : next_off;
                  state         <= enable ? S_WAIT : S_IDLE;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_circular_dma_burst_sched.sv
// tb_circular_dma_burst_sched: self-checking bench for the circular DMA burst scheduler
module tb_circular_dma_burst_sched;
   logic        clk = 0, rst, enable, srst, flush_fifo, cmd_valid, cmd_ready, done_valid, done_err;
   logic [31:0] mem_base, mem_size, timeout, cmd_addr, bytes_written;
   logic [15:0] fifo_words;
   logic [7:0]  cmd_len;
   logic [2:0]  status_flags, irq, clear_irq;
   int errors = 0, checks = 0;
   localparam logic [31:0] BASE = 32'h1000_0000;

   always #5 clk = ~clk;

   circular_dma_burst_sched #(.C_ADDR_WIDTH(32), .C_AXIS_WIDTH(64), .C_MAX_BURST(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .srst(srst), .mem_base(mem_base), .mem_size(mem_size),
      .timeout(timeout), .fifo_words(fifo_words), .flush_fifo(flush_fifo), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .done_valid(done_valid),
      .done_err(done_err), .bytes_written(bytes_written), .status_flags(status_flags), .irq(irq),
      .clear_irq(clear_irq)
   );

   task automatic restart(input logic [31:0] base, input logic [31:0] size, input logic [31:0] tmo);
      @(negedge clk);
      enable = 0; fifo_words = 0; flush_fifo = 0; cmd_ready = 0; srst = 1;
      @(negedge clk);
      srst = 0; mem_base = base; mem_size = size; timeout = tmo; enable = 1;
      @(negedge clk);
   endtask

   task automatic get_cmd(input int budget, output bit ok, output int cycles);
      ok = 0; cycles = 0;
      while (!ok && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (cmd_valid) ok = 1;
      end
   endtask

   task automatic finish_burst(input bit err);
      cmd_ready = 1;
      @(negedge clk);
      cmd_ready = 0; done_valid = 1; done_err = err;
      @(negedge clk);
      done_valid = 0; done_err = 0;
   endtask

   task automatic test_reset;
      rst = 1; srst = 0; enable = 0; mem_base = BASE; mem_size = 32'h400; timeout = 100;
      fifo_words = 0; flush_fifo = 0; cmd_ready = 0; done_valid = 0; done_err = 0; clear_irq = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({cmd_valid, cmd_addr, cmd_len, bytes_written} !== '0)
         $display("FAIL reset_cmd: got valid=%b addr=%h len=%h bw=%h required all 0", cmd_valid, cmd_addr, cmd_len, bytes_written);
      checks++;
      if ({status_flags, irq} !== 6'd0)
         $display("FAIL reset_flags: got status=%b irq=%b required 0", status_flags, irq);
      if ({cmd_valid, cmd_addr, cmd_len, bytes_written} !== '0 || {status_flags, irq} !== 6'd0) errors++;
      rst = 0;
   endtask

   task automatic test_full_burst;
      bit ok; int cyc;
      restart(BASE, 32'h400, 100);
      fifo_words = 16; cmd_ready = 1;
      get_cmd(10, ok, cyc);
      checks++; if (!ok) begin errors++; $display("FAIL full_cmd_seen: got none required cmd_valid"); end
      checks++; if (cmd_addr !== BASE) begin errors++; $display("FAIL full_addr: got %h required %h", cmd_addr, BASE); end
      checks++; if (cmd_len !== 8'd15) begin errors++; $display("FAIL full_len: got %0d required 15", cmd_len); end
      checks++; if (status_flags !== 3'b001) begin errors++; $display("FAIL full_busy: got %b required 001", status_flags); end
      fifo_words = 0;
      finish_burst(0);
      checks++; if (bytes_written !== 32'h80) begin errors++; $display("FAIL full_bw: got %h required 80", bytes_written); end
   endtask

   task automatic test_timeout;
      bit ok; int cyc;
      restart(BASE, 32'h400, 100);
      fifo_words = 3;
      @(negedge clk);
      checks++; if (status_flags !== 3'b010) begin errors++; $display("FAIL tmo_waiting: got %b required 010", status_flags); end
      get_cmd(300, ok, cyc);
      checks++; if (!ok || cyc != 99) begin errors++; $display("FAIL tmo_delay: got ok=%0d cycles=%0d required 99", ok, cyc); end
      checks++; if (cmd_len !== 8'd2 || cmd_addr !== BASE) begin errors++; $display("FAIL tmo_cmd: got len=%0d addr=%h required 2 %h", cmd_len, cmd_addr, BASE); end
      checks++; if (irq !== 3'b001) begin errors++; $display("FAIL tmo_irq: got %b required 001", irq); end
      fifo_words = 0;
      finish_burst(0);
      checks++; if (bytes_written !== 32'd24) begin errors++; $display("FAIL tmo_bw: got %h required 18", bytes_written); end
      clear_irq = 3'b001;
      @(negedge clk);
      clear_irq = 0;
      checks++; if (irq !== 3'b000) begin errors++; $display("FAIL tmo_clear: got %b required 000", irq); end
   endtask

   task automatic test_wrap;
      bit ok; int cyc;
      restart(BASE, 32'h400, 100);
      fifo_words = 16;
      for (int i = 0; i < 8; i++) begin
         get_cmd(10, ok, cyc);
         checks++;
         if (!ok || cmd_addr !== BASE + 32'(i) * 32'h80 || cmd_len !== 8'd15) begin
            errors++;
            $display("FAIL wrap_cmd%0d: got ok=%0d addr=%h len=%0d required %h 15", i, ok, cmd_addr, cmd_len, BASE + 32'(i) * 32'h80);
         end
         finish_burst(0);
      end
      checks++; if (bytes_written !== 0 || irq !== 3'b010) begin errors++; $display("FAIL wrap_state: got bw=%h irq=%b required 0 010", bytes_written, irq); end
      get_cmd(10, ok, cyc);
      checks++; if (!ok || cmd_addr !== BASE) begin errors++; $display("FAIL wrap_next: got ok=%0d addr=%h required %h", ok, cmd_addr, BASE); end
   endtask

   task automatic test_4k_split;
      bit ok; int cyc;
      restart(32'h1000_0FC0, 32'h400, 100);
      fifo_words = 16;
      get_cmd(10, ok, cyc);
      checks++; if (!ok || cmd_len !== 8'd7 || cmd_addr !== 32'h1000_0FC0) begin errors++; $display("FAIL split_first: got ok=%0d addr=%h len=%0d required 10000fc0 7", ok, cmd_addr, cmd_len); end
      finish_burst(0);
      checks++; if (bytes_written !== 32'h40) begin errors++; $display("FAIL split_bw: got %h required 40", bytes_written); end
      get_cmd(10, ok, cyc);
      checks++; if (!ok || cmd_addr !== 32'h1000_1000 || cmd_len !== 8'd15) begin errors++; $display("FAIL split_second: got ok=%0d addr=%h len=%0d required 10001000 15", ok, cmd_addr, cmd_len); end
   endtask

   task automatic test_error;
      bit ok, saw; int cyc;
      restart(BASE, 32'h400, 100);
      fifo_words = 16;
      get_cmd(10, ok, cyc);
      finish_burst(1);
      checks++; if (irq !== 3'b100 || status_flags !== 3'b100) begin errors++; $display("FAIL err_flags: got irq=%b status=%b required 100 100", irq, status_flags); end
      saw = 0;
      repeat (20) begin @(negedge clk); if (cmd_valid) saw = 1; end
      checks++; if (saw) begin errors++; $display("FAIL err_quiet: got cmd_valid=1 required 0"); end
      enable = 0; srst = 1;
      @(negedge clk);
      srst = 0;
      checks++;
      if ({cmd_valid, cmd_addr, cmd_len, bytes_written, status_flags, irq} !== '0) begin
         errors++;
         $display("FAIL err_srst: got valid=%b addr=%h len=%h bw=%h status=%b irq=%b required all 0", cmd_valid, cmd_addr, cmd_len, bytes_written, status_flags, irq);
      end
      mem_size = 32'h40; enable = 1;
      @(negedge clk);
      checks++; if (status_flags !== 3'b100) begin errors++; $display("FAIL err_badcfg: got %b required 100", status_flags); end
   endtask

   task automatic test_disable;
      bit ok, stable, saw; int cyc;
      logic [31:0] a; logic [7:0] l;
      restart(BASE, 32'h400, 100);
      fifo_words = 16;
      get_cmd(10, ok, cyc);
      a = cmd_addr; l = cmd_len;
      enable = 0; stable = ok;
      repeat (5) begin @(negedge clk); if (!cmd_valid || cmd_addr !== a || cmd_len !== l) stable = 0; end
      checks++; if (!stable) begin errors++; $display("FAIL dis_hold: got valid=%b addr=%h len=%0d required 1 %h %0d", cmd_valid, cmd_addr, cmd_len, a, l); end
      finish_burst(0);
      checks++; if (status_flags !== 3'b000 || bytes_written !== 32'h80) begin errors++; $display("FAIL dis_idle: got status=%b bw=%h required 000 80", status_flags, bytes_written); end
      saw = 0;
      repeat (10) begin @(negedge clk); if (cmd_valid) saw = 1; end
      checks++; if (saw) begin errors++; $display("FAIL dis_quiet: got cmd_valid=1 required 0"); end
   endtask

   task automatic test_random;
      logic [31:0] bases[3] = '{32'h1000_0000, 32'h2000_0F00, 32'h3000_0E08};
      logic [31:0] sizes[3] = '{32'h400, 32'h800, 32'h180};
      bit ok; int cyc, d;
      logic [31:0] base, size, off, a, bt, pg, rem;
      bit wr;
      for (int r = 0; r < 3; r++) begin
         base = bases[r]; size = sizes[$urandom_range(0, 2)];
         restart(base, size, 0);
         off = 0; wr = 0;
         for (int n = 0; n < 30; n++) begin
            fifo_words = 16'($urandom_range(1, 24)); flush_fifo = 1;
            get_cmd(10, ok, cyc);
            a = base + off;
            pg = (4096 - (a % 4096)) / 8;
            rem = (size - off) / 8;
            bt = {16'd0, fifo_words};
            if (bt > 16) bt = 16;
            if (bt > rem) bt = rem;
            if (bt > pg) bt = pg;
            checks++;
            if (!ok || cmd_addr !== a || cmd_len !== 8'(bt - 1)) begin
               errors++;
               $display("FAIL rand_cmd r%0d n%0d: got ok=%0d addr=%h len=%0d required %h %0d", r, n, ok, cmd_addr, cmd_len, a, bt - 1);
            end
            d = $urandom_range(0, 3);
            if (d > 0) begin
               repeat (d) @(negedge clk);
               checks++;
               if (!cmd_valid || cmd_addr !== a) begin errors++; $display("FAIL rand_hold r%0d n%0d: got valid=%b addr=%h required 1 %h", r, n, cmd_valid, cmd_addr, a); end
            end
            finish_burst(0);
            off = off + bt * 8;
            if (off == size) begin off = 0; wr = 1; end
            checks++;
            if (bytes_written !== off || irq[1] !== wr) begin
               errors++;
               $display("FAIL rand_bw r%0d n%0d: got bw=%h wrapped=%b required %h %b", r, n, bytes_written, irq[1], off, wr);
            end
         end
      end
      flush_fifo = 0;
   endtask

   initial begin
      test_reset;
      test_full_burst;
      test_timeout;
      test_wrap;
      test_4k_split;
      test_error;
      test_disable;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
